// File: rtl/apb_master_wait.sv
// apb_master_wait
//   APB requester with wait-state support and a bounded wait timeout.
//   Takes one read/write command at a time from a valid/ready port, runs the
//   APB SETUP/ACCESS sequence and returns exactly one response per command.
//
// Parameters:
//   ADDR_W   APB address width
//   DATA_W   APB data width
//   TIMEOUT  max ACCESS cycles with pready low before abort (0 = no timeout)
//
// Ports:
//   pclk, presetn               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FSM idle)
//   cmd_write/cmd_addr/cmd_wdata command fields, captured on handshake
//   rsp_valid/rsp_rdata/rsp_err one-cycle response; rdata is 0 for writes
//                               and for timeouts, err marks a timeout
//   paddr/psel/penable/pwrite/pwdata/prdata/pready  APB requester side
module apb_master_wait #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // Counter wide enough to hold TIMEOUT exactly; at least one bit so the
  // TIMEOUT = 0 build still has a legal (saturating) counter.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;

  logic              psel_next;
  logic              penable_next;
  logic [ADDR_W-1:0] paddr_next;
  logic              pwrite_next;
  logic [DATA_W-1:0] pwdata_next;
  logic              rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_next;
  logic              rsp_err_next;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      psel      <= psel_next;
      penable   <= penable_next;
      paddr     <= paddr_next;
      pwrite    <= pwrite_next;
      pwdata    <= pwdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    psel_next      = psel;
    penable_next   = penable;
    paddr_next     = paddr;
    pwrite_next    = pwrite;
    pwdata_next    = pwdata;
    rsp_valid_next = 1'b0;          // response is always a single-cycle pulse
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;

    case (state)
      IDLE: begin
        psel_next    = 1'b0;
        penable_next = 1'b0;
        if (cmd_valid) begin
          state_next    = SETUP;
          psel_next     = 1'b1;
          paddr_next    = cmd_addr;
          pwrite_next   = cmd_write;
          pwdata_next   = cmd_wdata;
          wait_cnt_next = '0;
        end
      end

      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end

      ACCESS: begin
        // pready is checked first so a completion on the timeout edge wins.
        if (pready) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = pwrite ? '0 : prdata;
        end else if ((TIMEOUT > 0) && (wait_cnt == CNT_LIMIT)) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end

      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_wait.sv
// tb_apb_master_wait
//   Self-checking bench for apb_master_wait. A byte-array completer answers
//   the bus with a chosen number of wait states; expected responses come from
//   the transfer rules (latency 2 + waits, abort after TIMEOUT+1 waited ACCESS
//   cycles, pready wins a tie) and a separate reference memory.
module tb_apb_master_wait;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  logic              pclk;
  logic              presetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  apb_master_wait #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] slave_mem [16];   // completer storage (drives prdata)
  logic [7:0] ref_mem   [16];   // expectation model

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and follows it cycle by cycle. Called just after a
  // rising edge with the DUT idle; returns in the response cycle. With hold
  // set, cmd_valid is left high so the caller can chain the next command.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input int waits, input logic exp_err,
                         input logic [7:0] exp_rdata, input bit hold);
    int   n_acc;
    logic store;
    store     = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    pready    = 1'($urandom);
    prdata    = 8'($urandom);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge pclk); #1;
    if (!hold) cmd_valid = 1'b0;
    cmd_addr  = 4'($urandom);          // fields must already be latched
    cmd_wdata = 8'($urandom);
    cmd_write = 1'($urandom);
    pready    = 1'($urandom);          // ignored in SETUP
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, d);
    chk("setup_rsp_valid", rsp_valid, 0);
    chk("setup_cmd_ready", cmd_ready, 0);
    n_acc = (waits <= TIMEOUT) ? waits + 1 : TIMEOUT + 1;
    for (int i = 0; i < n_acc; i++) begin
      @(posedge pclk); #1;
      if (store) slave_mem[a] = d;
      store  = 1'b0;
      pready = (i == waits);
      prdata = (i == waits && !wr) ? slave_mem[a] : 8'($urandom);
      if (i == waits && wr) store = 1'b1;
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwrite", pwrite, wr);
      chk("access_pwdata", pwdata, d);
      chk("access_rsp_valid", rsp_valid, 0);
      chk("access_cmd_ready", cmd_ready, 0);
    end
    @(posedge pclk); #1;
    if (store) slave_mem[a] = d;
    pready = 1'($urandom);
    prdata = 8'($urandom);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    chk("rsp_cmd_ready", cmd_ready, 1);
    $display("txn wr=%0d addr=0x%0h wdata=0x%02h waits=%0d -> err=%0d rdata=0x%02h",
             wr, a, d, waits, rsp_err, rsp_rdata);
  endtask

  vec_t vecs [9];
  time  t1, t2;

  initial begin
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = 8'(i * 13 + 1);
      ref_mem[i]   = 8'(i * 13 + 1);
    end
    slave_mem[7] = 8'h5C; ref_mem[7] = 8'h5C;
    slave_mem[9] = 8'h11; ref_mem[9] = 8'h11;

    //              wr    addr   wdata  waits err   rdata
    vecs[0] = '{1'b1, 4'h3, 8'hA5, 0,  1'b0, 8'h00};  // zero-wait write
    vecs[1] = '{1'b0, 4'h3, 8'h00, 0,  1'b0, 8'hA5};  // read it back
    vecs[2] = '{1'b0, 4'h7, 8'h00, 3,  1'b0, 8'h5C};  // 3 wait states
    vecs[3] = '{1'b1, 4'h5, 8'h3C, 20, 1'b1, 8'h00};  // write times out
    vecs[4] = '{1'b0, 4'h5, 8'h00, 0,  1'b0, 8'h42};  // aborted write not stored
    vecs[5] = '{1'b0, 4'h9, 8'h00, 15, 1'b0, 8'h11};  // tie: pready wins
    vecs[6] = '{1'b0, 4'h2, 8'h00, 16, 1'b1, 8'h00};  // read times out
    vecs[7] = '{1'b1, 4'h0, 8'hFF, 1,  1'b0, 8'h00};
    vecs[8] = '{1'b0, 4'h0, 8'h00, 2,  1'b0, 8'hFF};

    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; prdata = '0; pready = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      run_cmd(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits,
              vecs[v].exp_err, vecs[v].exp_rdata, 1'b0);
      if (vecs[v].wr && !vecs[v].exp_err) ref_mem[vecs[v].addr] = vecs[v].wdata;
    end
    @(posedge pclk); #1;
    chk("rsp_valid_single_pulse", rsp_valid, 0);

    // Back-to-back with cmd_valid held high
    run_cmd(1'b1, 4'h1, 8'h22, 0, 1'b0, 8'h00, 1'b1);
    ref_mem[1] = 8'h22;
    t1 = $time;
    run_cmd(1'b0, 4'h1, 8'h00, 0, 1'b0, 8'h22, 1'b1);
    t2 = $time;
    cmd_valid = 1'b0;
    chk("b2b_spacing_cycles", 32'((t2 - t1) / 10), 3);
    @(posedge pclk); #1;
    chk("b2b_no_extra_rsp", rsp_valid, 0);
    chk("b2b_idle_psel", psel, 0);

    // Reset in the middle of a waited read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4; pready = 1'b0;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("pre_reset_penable", penable, 1);
    presetn = 1'b0;
    #1;
    chk("async_reset_psel", psel, 0);
    chk("async_reset_penable", penable, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    chk("async_reset_paddr", paddr, 0);
    chk("async_reset_cmd_ready", cmd_ready, 1);
    @(posedge pclk); #1;
    presetn = 1'b1;
    pready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk("post_reset_no_rsp", rsp_valid, 0);
      chk("post_reset_psel", psel, 0);
    end
    run_cmd(1'b0, 4'h4, 8'h00, 1, 1'b0, ref_mem[4], 1'b0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 30; n++) begin
      logic       wr;
      logic [3:0] a;
      logic [7:0] d;
      int         waits;
      logic       err;
      logic [7:0] exp_rd;
      int         gap;
      wr    = 1'($urandom);
      a     = 4'($urandom);
      d     = 8'($urandom);
      waits = $urandom_range(0, 18);
      err   = (waits > TIMEOUT);
      exp_rd = (wr || err) ? 8'h00 : ref_mem[a];
      run_cmd(wr, a, d, waits, err, exp_rd, 1'b0);
      if (wr && !err) ref_mem[a] = d;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge pclk); #1;
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_psel", psel, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_wait.md
# apb_master_wait

APB requester (master) with wait-state support and a bounded wait timeout. Accepts single read/write commands from a local valid/ready command port, runs the APB SETUP/ACCESS sequence on the bus, and returns one response per command. It sits opposite the team's wait-capable APB completer, which can hold `pready` low for any number of cycles.

## Interface
Parameters:
- `ADDR_W`, default 4: APB address width.
- `DATA_W`, default 8: APB data width.
- `TIMEOUT`, default 15: maximum number of ACCESS cycles with `pready` low before the transfer is aborted. 0 disables the timeout.

Ports:
- `pclk`  in  1: single clock; all logic is on the rising edge.
- `presetn`  in  1: reset, asynchronous, active-low.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_write`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W: target address.
- `cmd_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  DATA_W: read data. 0 for writes and for errors.
- `rsp_err`  out  1: transfer aborted by timeout. Qualified by `rsp_valid`.
- `paddr`  out  ADDR_W: APB address.
- `psel`  out  1: APB select.
- `penable`  out  1: APB enable.
- `pwrite`  out  1: APB direction.
- `pwdata`  out  DATA_W: APB write data.
- `prdata`  in  DATA_W: APB read data.
- `pready`  in  1: APB completer ready.

## Operation
- Three-state FSM: IDLE, SETUP, ACCESS. All outputs are registered, except `cmd_ready`, which is decoded as (state == IDLE).
- IDLE:
  - `psel` = 0 and `penable` = 0.
  - A handshake (`cmd_valid` and `cmd_ready`) latches `cmd_write`, `cmd_addr` and `cmd_wdata` into `pwrite`, `paddr` and `pwdata`, then moves to SETUP.
- SETUP:
  - `psel` = 1, `penable` = 0.
  - Always advances to ACCESS after exactly one cycle.
- ACCESS:
  - `psel` = 1, `penable` = 1.
  - `paddr`, `pwrite` and `pwdata` stay stable for the whole of SETUP and ACCESS.
  - `pready` high at a rising edge completes the transfer and returns to IDLE:
    - read: `rsp_rdata` <= `prdata`;
    - write: `rsp_rdata` <= 0;
    - in both cases `rsp_err` <= 0 and `rsp_valid` <= 1 for one cycle.
  - `pready` low: the wait counter increments and the FSM stays in ACCESS.
- Timeout (TIMEOUT > 0): on the edge where `pready` is low and the wait counter already equals TIMEOUT, the FSM aborts to IDLE with `rsp_valid` = 1, `rsp_err` = 1 and `rsp_rdata` = 0.
- Wait counter:
  - cleared on entry to SETUP;
  - its width holds TIMEOUT without wrap and saturates, so it never wraps.
- Simultaneous events: `pready` high on the same edge the timeout would fire means normal completion; `pready` wins.
- `pready` and `prdata` are ignored outside ACCESS.
- In IDLE, `paddr`, `pwrite` and `pwdata` hold their last values.
- Exactly one response per accepted command; no command is ever dropped.
- Reset, including mid-transfer:
  - all outputs go to 0 immediately: `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`;
  - state goes to IDLE and `cmd_ready` = 1 after reset;
  - the in-flight transfer is discarded with no response.

## Timing
- Command accepted at edge T:
  - SETUP during cycle T..T+1;
  - ACCESS from T+1.
- Zero-wait transfer:
  - `pready` is sampled high at edge T+2;
  - `rsp_valid` is high during T+2..T+3, with `cmd_ready` = 1 in the same cycle;
  - the earliest next accept is edge T+3.
  - Peak throughput is one transfer per 3 cycles.
- N wait cycles: the response is delayed by N cycles, giving `rsp_valid` at edge T+2+N.
- Timeout: `rsp_valid` with `rsp_err` at edge T+2+TIMEOUT. `psel` is low from that edge onward.
- `rsp_valid` is never high for two consecutive cycles.

## Test plan
- Zero-wait write: cmd (write, addr 0x3, data 0xA5) with `pready` tied high -> `psel` is high for exactly 2 cycles, `penable` is high for 1 cycle, `paddr` = 0x3 and `pwdata` = 0xA5 are stable throughout, and `rsp_valid` pulses once with `rsp_err` = 0.
- Read with 3 wait states: cmd (read, addr 0x7); `pready` goes high on the 4th ACCESS cycle with `prdata` = 0x5C -> `rsp_valid` 5 cycles after accept, `rsp_rdata` = 0x5C, and `penable` high for 4 cycles.
- Timeout: TIMEOUT = 15 with `pready` stuck low -> abort after 16 ACCESS cycles, then `rsp_err` = 1, `rsp_rdata` = 0, `psel` = 0, and `cmd_ready` = 1.
- Timeout tie: `pready` rises on exactly the edge the timeout would fire, with `prdata` = 0x11 -> `rsp_err` = 0 and `rsp_rdata` = 0x11.
- Back-to-back: `cmd_valid` held high with write 0x1/0x22 and then read 0x1, against a completer that stores writes -> two responses 3 cycles apart, with `rsp_rdata` = 0x22 on the second.
- Reset mid-ACCESS: assert `presetn` low during a waited read -> `psel`, `penable` and `rsp_valid` go to 0 asynchronously, no response appears after release, and the next command completes normally.
